// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - device bus between the data-memory stage and the countdown timer
interface timer_dev_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  modport master (output Addr, WE, WD, input RD, IRQ);
  modport slave  (input Addr, WE, WD, output RD, IRQ);
endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer (CTRL/PRESET/COUNT) with IRQ to CP0
// Optional TIMER_PRESCALE_EN stores a prescale exponent in CTRL[4+PSC_W-1:4].
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter int          PSC_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  timer_dev_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        irq_q;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        tick;
  logic        flag_nxt;
  logic        im_nxt;
  logic [31:0] ctrl_rd;

`ifdef TIMER_PRESCALE_EN
  localparam int PC_W = 2 ** PSC_W;
  logic [PSC_W-1:0] psc;
  logic [PC_W-1:0]  pcnt;
  logic [PC_W-1:0]  psc_mask;

  assign psc_mask = ~({PC_W{1'b1}} << psc);
  assign tick     = (pcnt == psc_mask);
  assign ctrl_rd  = {{(28-PSC_W){1'b0}}, psc, im, mode, en};
`else
  assign tick     = 1'b1;
  assign ctrl_rd  = {28'd0, im, mode, en};
`endif

  assign ctrl_wr     = bus.WE && (bus.Addr[3:2] == 2'd0);
  assign preset_wr   = bus.WE && (bus.Addr[3:2] == 2'd1);
  assign auto_reload = (mode == 2'b01);

  // IRQ is registered from the flag's next value so it rises on the same edge as the flag.
  always_comb begin
    flag_nxt = irq_flag;
    if (ctrl_wr)
      flag_nxt = 1'b0;
    else if (state == CNT && en && tick && count <= 32'd1)
      flag_nxt = 1'b1;
    else if (state == INT && auto_reload && en)
      flag_nxt = 1'b0;
    im_nxt = ctrl_wr ? bus.WD[3] : im;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= PRESET_RST;
      count    <= 32'd0;
      irq_flag <= 1'b0;
      irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc      <= '0;
      pcnt     <= '0;
`endif
    end else begin
      irq_flag <= flag_nxt;
      irq_q    <= im_nxt & flag_nxt;
      if (preset_wr)
        preset <= bus.WD;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= 32'd0;
              state <= INT;
              if (!auto_reload)
                en <= 1'b0;
            end
          end
        end
        INT: state <= (auto_reload && en) ? LOAD : IDLE;
        default: state <= IDLE;
      endcase

`ifdef TIMER_PRESCALE_EN
      // Clearing on every non-counting cycle covers LOAD, exit from CNT and each tick.
      if (state == CNT && en && !tick)
        pcnt <= pcnt + 1'b1;
      else
        pcnt <= '0;
`endif

      // Placed after the FSM so a CPU write overrides the one-shot En clear.
      if (ctrl_wr) begin
        en   <= bus.WD[0];
        mode <= bus.WD[2:1];
        im   <= bus.WD[3];
`ifdef TIMER_PRESCALE_EN
        psc  <= bus.WD[4+PSC_W-1:4];
`endif
      end
    end
  end

  always_comb begin
    case (bus.Addr[3:2])
      2'd0:    bus.RD = ctrl_rd;
      2'd1:    bus.RD = preset;
      2'd2:    bus.RD = count;
      default: bus.RD = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_q;

  logic unused_addr;
  assign unused_addr = &{1'b0, bus.Addr[31:4], bus.Addr[1:0]};

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - scoreboard bench for timer_dev
module tb_timer_dev;

  localparam logic [31:0] PRST = 32'h0000_1234;

  logic clk;
  logic reset;
  timer_dev_if bus ();

  timer_dev #(.PRESET_RST(PRST), .PSC_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] count;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.RD;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.WD   = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] c, input logic q);
    exp_t e;
    e.count = c;
    e.irq   = q;
    exp_q.push_back(e);
  endtask

  task automatic step_sample(output logic [31:0] c, output logic q);
    tick();
    rd(32'h8, c);
    q = bus.IRQ;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    do_reset();
    rd(32'h0, d);
    n_total++; if (d !== 32'h0) $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h0); else n_pass++;
    rd(32'h4, d);
    n_total++; if (d !== PRST) $display("FAIL reset_preset got=%h exp=%h", d, PRST); else n_pass++;
    rd(32'h8, d);
    n_total++; if (d !== 32'h0) $display("FAIL reset_count got=%h exp=%h", d, 32'h0); else n_pass++;
    n_total++; if (bus.IRQ !== 1'b0) $display("FAIL reset_irq got=%b exp=0", bus.IRQ); else n_pass++;
  endtask

  task automatic test_one_shot;
    logic [31:0] c, d;
    logic q;
    exp_t e;
    do_reset();
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      push_exp((k == 1) ? 32'd0 : 32'(7 - k), k == 7);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL one_shot k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    rd(32'h0, d);
    n_total++; if (d !== 32'h8) $display("FAIL one_shot_ctrl got=%h exp=%h", d, 32'h8); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      push_exp(32'd0, 1'b1);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL one_shot_hold k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    wr(32'h0, 32'h0);
    n_total++; if (bus.IRQ !== 1'b0) $display("FAIL one_shot_clear irq=%b exp=0", bus.IRQ); else n_pass++;
  endtask

  task automatic test_auto_reload;
    logic [31:0] c;
    logic q;
    exp_t e;
    int ph;
    do_reset();
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      ph = (k - 2) % 5;
      if (k == 1) push_exp(32'd0, 1'b0);
      else push_exp((ph < 3) ? 32'(3 - ph) : 32'd0, ph == 3);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL auto_reload k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
  endtask

  task automatic test_masked_disable;
    logic [31:0] c, d;
    logic q;
    exp_t e;
    do_reset();
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    for (int k = 1; k <= 14; k++) begin
      push_exp((k == 1 || k >= 12) ? 32'd0 : 32'(12 - k), 1'b0);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL masked k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    rd(32'h0, d);
    n_total++; if (d !== 32'h0) $display("FAIL masked_ctrl got=%h exp=%h", d, 32'h0); else n_pass++;

    do_reset();
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      push_exp((k == 1) ? 32'd0 : 32'(12 - k), 1'b0);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL disable_pre k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    wr(32'h0, 32'h8);
    for (int k = 0; k < 6; k++) begin
      push_exp(32'd6, 1'b0);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL disable_frozen k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    rd(32'h0, d);
    n_total++; if (d !== 32'h8) $display("FAIL disable_ctrl got=%h exp=%h", d, 32'h8); else n_pass++;
  endtask

  task automatic test_boundary;
    logic [31:0] c, d;
    logic q;
    exp_t e;
    do_reset();
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      push_exp(32'd0, k == 3);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL preset_zero k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    wr(32'h8, 32'h0000_FFFF);
    rd(32'h8, d);
    n_total++; if (d !== 32'h0) $display("FAIL count_write got=%h exp=%h", d, 32'h0); else n_pass++;
    n_total++; if (bus.IRQ !== 1'b1) $display("FAIL count_write_irq got=%b exp=1", bus.IRQ); else n_pass++;
    wr(32'hC, 32'hFFFF_FFFF);
    rd(32'hC, d);
    n_total++; if (d !== 32'h0) $display("FAIL unmapped_rd got=%h exp=%h", d, 32'h0); else n_pass++;
    rd(32'h0, d);
    n_total++; if (d !== 32'h8) $display("FAIL unmapped_wr_ctrl got=%h exp=%h", d, 32'h8); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] c, d;
    logic q;
    exp_t e;
    do_reset();
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      push_exp((k == 1) ? 32'd0 : 32'(12 - k), 1'b0);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL reset_mid_pre k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    reset = 1'b0;
    wr(32'h0, 32'h9);
    reset = 1'b1;
    rd(32'h0, d);
    n_total++; if (d !== 32'h0) $display("FAIL reset_mid_ctrl got=%h exp=%h", d, 32'h0); else n_pass++;
    rd(32'h4, d);
    n_total++; if (d !== PRST) $display("FAIL reset_mid_preset got=%h exp=%h", d, PRST); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      push_exp(32'd0, 1'b0);
      if (k > 0) step_sample(c, q);
      else begin rd(32'h8, c); q = bus.IRQ; end
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL reset_mid_idle k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
  endtask

  task automatic test_prescale;
    logic [31:0] c, d;
    logic q;
    exp_t e;
    do_reset();
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h29);
`ifdef TIMER_PRESCALE_EN
    rd(32'h0, d);
    n_total++; if (d !== 32'h29) $display("FAIL psc_ctrl got=%h exp=%h", d, 32'h29); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      push_exp((k == 1 || k == 10) ? 32'd0 : (k <= 5) ? 32'd2 : 32'd1, k == 10);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL prescale k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    rd(32'h0, d);
    n_total++; if (d !== 32'h28) $display("FAIL psc_ctrl_end got=%h exp=%h", d, 32'h28); else n_pass++;
`else
    rd(32'h0, d);
    n_total++; if (d !== 32'h9) $display("FAIL psc_ctrl got=%h exp=%h", d, 32'h9); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      push_exp((k == 1) ? 32'd0 : 32'(4 - k), k == 4);
      step_sample(c, q);
      e = exp_q.pop_front();
      n_total++;
      if (c !== e.count || q !== e.irq)
        $display("FAIL no_prescale k=%0d count=%0d irq=%b exp count=%0d irq=%b", k, c, q, e.count, e.irq);
      else n_pass++;
    end
    rd(32'h0, d);
    n_total++; if (d !== 32'h8) $display("FAIL psc_ctrl_end got=%h exp=%h", d, 32'h8); else n_pass++;
`endif
  endtask

  initial begin
    reset    = 1'b0;
    bus.Addr = 32'h0;
    bus.WE   = 1'b0;
    bus.WD   = 32'h0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_masked_disable();
    test_boundary();
    test_reset_mid();
    test_prescale();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the processor's device bus.
- Sits downstream of the data-memory stage: consumes that stage's device write-enable, address and write data, and returns read data plus an interrupt request to CP0.
- Occupies three word registers: CTRL at offset 0x0, PRESET at 0x4, COUNT at 0x8.
- Offsets 0x0 and 0x4 are writable; all three are readable.

Parameters:
- PRESET_RST, 32'h0000_0000, reset value of PRESET.
- PSC_W, 4, width of the prescale field. Used only with TIMER_PRESCALE_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low. Sampled on posedge clk; reset==0 initialises the block.
- Addr  in  32  device byte address. Only Addr[3:2] are decoded: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- WE  in  1  device write enable; one-cycle write strobe.
- WD  in  32  write data.
- RD  out  32  combinational read data for Addr[3:2]. Unmapped offset reads 0.
- IRQ  out  1  interrupt request to CP0; registered.

Behaviour:
- Reset (reset==0 at posedge):
  - CTRL=0, PRESET=PRESET_RST, COUNT=0.
  - state=IDLE, irq flag=0, IRQ=0.
  - Reset overrides any write or count in the same cycle, including mid-count.
- CTRL fields:
  - [0] En.
  - [2:1] Mode: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0.
  - [3] IM, interrupt mask.
  - Other bits are not stored and read 0.
- Writes:
  - On posedge with WE=1, Addr[3:2]=0 stores WD[3:0] into CTRL; Addr[3:2]=1 stores WD into PRESET.
  - Writes to COUNT or the unmapped offset are ignored.
  - Any CTRL write clears the irq flag.
  - A CPU CTRL write in the same cycle as an FSM update of En: the CPU write wins.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: En=1 → LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT:
    - En=0 → IDLE, COUNT frozen.
    - COUNT>1 → COUNT<=COUNT-1, stay.
    - COUNT<=1 → COUNT<=0 → INT, irq flag<=1. In Mode 0, CTRL.En<=0 on this same edge.
  - INT:
    - Mode 1 with En=1 → LOAD, irq flag<=0.
    - Otherwise → IDLE. In Mode 0 the irq flag holds until a CTRL write or reset.
- IRQ = IM & irq flag, registered. Mode 1 therefore gives a one-cycle IRQ pulse per period.
- Latency, from the edge that writes En=1 while in IDLE:
  - LOAD after 1 edge; CNT with COUNT=N after 2 edges.
  - IRQ rises after N+2 edges for N>=1, after 3 edges for N=0.
  - Mode 1 period is N+2 cycles.
- PRESET written mid-count: takes effect at the next LOAD only.
- Decrement wraps never: COUNT stops at 0.
- RD is combinational; COUNT is read live, with no extra latency.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- With the macro defined:
  - CTRL[4+PSC_W-1:4] is stored as P and reads back.
  - An internal prescale counter advances in CNT.
  - COUNT decrements only when 2^P cycles have elapsed since LOAD or since the previous decrement.
  - The prescale counter clears on LOAD, on leaving CNT, and on reset.
  - P=0 is identical to the non-prescaled behaviour.
- Without the macro: those bits read 0, there is no prescale counter, and COUNT decrements every CNT cycle.

Test Plan:
- One-shot: reset pulse low; write PRESET=5, CTRL=0x9 (IM=1, Mode 0, En=1) → COUNT reads 5,4,3,2,1,0; IRQ=1 exactly 7 edges after the CTRL write; CTRL reads 0x8 (En cleared); IRQ stays 1 until a CTRL write of 0 drops it next edge.
- Auto-reload: PRESET=3, CTRL=0xB → IRQ one-cycle pulses every 5 cycles, at least 3 pulses; COUNT reloads 3 after each.
- Masked/disable: PRESET=10, CTRL=0x1 (IM=0) → IRQ never rises. In a second run with CTRL=0x9 (IM=1), write CTRL=0x8 when COUNT=6 → COUNT frozen at 6, state IDLE, IRQ stays 0.
- Boundary: PRESET=0, CTRL=0x9 → IRQ high 3 edges after the write. A write to COUNT (Addr=0x8, WD=0xFFFF) is ignored. RD at Addr 0xC reads 0.
- Reset mid-operation: drive reset=0 with COUNT=4 in CNT → next edge COUNT=0, CTRL=0, IRQ=0, state IDLE; a simultaneous WE write is discarded.
- TIMER_PRESCALE_EN: P=2, PRESET=2, CTRL=0x29 → COUNT steps every 4 cycles; IRQ after 2+4*2 edges.
